// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard controller: EXE operand forwarding selects, load-use / RAW
// stall, branch flush, memory-wait freeze, wait watchdog and saturating
// stall/flush event counters.
module hazard_fwd_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_forward_en_i,
  input  logic [3:0]       id_src1_i,
  input  logic [3:0]       id_src2_i,
  input  logic             id_two_src_i,
  input  logic [3:0]       exe_src1_i,
  input  logic [3:0]       exe_src2_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_read_i,
  input  logic [3:0]       exe_dest_i,
  input  logic             exe_branch_i,
  input  logic             mem_wb_en_i,
  input  logic [3:0]       mem_dest_i,
  input  logic             wb_wb_en_i,
  input  logic [3:0]       wb_dest_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic [1:0]       sel_src1_o,
  output logic [1:0]       sel_src2_o,
  output logic             stall_front_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic             freeze_all_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StRun, StWait} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               fwd_en_q;

  logic               haz;
  logic               stall;

  // MEM result beats WB data when both write the operand's register.
  function automatic logic [1:0] fwd_sel(input logic       fwd_en,
                                         input logic [3:0] src,
                                         input logic       mem_en,
                                         input logic [3:0] mem_dest,
                                         input logic       wb_en,
                                         input logic [3:0] wb_dest);
    logic [1:0] sel;
    sel = 2'b00;
    if (fwd_en) begin
      if (mem_en && (mem_dest == src)) begin
        sel = 2'b01;
      end else if (wb_en && (wb_dest == src)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  // Does a producer writing dest collide with a source read by the ID instruction?
  function automatic logic hit(input logic [3:0] dest,
                               input logic       en,
                               input logic [3:0] src1,
                               input logic [3:0] src2,
                               input logic       two_src);
    return en && ((dest == src1) || (two_src && (dest == src2)));
  endfunction

  // Combinational forwarding, hazard, freeze, flush and stall decisions.
  always_comb begin
    sel_src1_o = fwd_sel(fwd_en_q, exe_src1_i, mem_wb_en_i, mem_dest_i, wb_wb_en_i, wb_dest_i);
    sel_src2_o = fwd_sel(fwd_en_q, exe_src2_i, mem_wb_en_i, mem_dest_i, wb_wb_en_i, wb_dest_i);

    // WB never hazards: the register file writes before it reads.
    if (fwd_en_q) begin
      haz = exe_mem_read_i &&
            hit(exe_dest_i, exe_wb_en_i, id_src1_i, id_src2_i, id_two_src_i);
    end else begin
      haz = hit(exe_dest_i, exe_wb_en_i, id_src1_i, id_src2_i, id_two_src_i) ||
            hit(mem_dest_i, mem_wb_en_i, id_src1_i, id_src2_i, id_two_src_i);
    end

    freeze_all_o  = mem_req_i && !mem_ready_i;
    // A branch during a freeze stays in EXE and flushes once the freeze releases.
    flush_o       = exe_branch_i && !freeze_all_o;
    stall         = haz && !freeze_all_o && !exe_branch_i;
    stall_front_o = stall;
    bubble_o      = stall;
  end

  // Next-state for the wait FSM, watchdog and saturating counters.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      StRun: begin
        wait_cnt_d = '0;
        if (freeze_all_o) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q != WaitW'(TIMEOUT)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (freeze_all_o && (wait_cnt_q >= WaitW'(TIMEOUT - 1))) begin
          timeout_d = 1'b1;
        end
        if (mem_ready_i || !mem_req_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_o && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fwd_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_en_q    <= cfg_forward_en_i;
    end
  end

  assign mem_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard controller for the 5-stage ARM core, covering forwarding, stalls, flushes and memory-wait freezes. Each cycle it computes the EXE-stage operand source selects `sel_src1`/`sel_src2` (00 register file, 01 MEM-stage ALU result, 10 WB data). It detects load-use and (forwarding-off) RAW hazards against the instruction in ID. It flushes on taken branches and freezes the whole pipeline while the memory stage waits on the SRAM controller. It also runs a memory-wait watchdog and saturating stall/flush performance counters.

## Interface
- `TIMEOUT`, 64: max consecutive memory-wait cycles before `mem_timeout` sets (≥2).
- `CNT_W`, 16: width of performance counters.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_forward_en` in 1: forwarding enable, registered into `fwd_en_q`.
- `id_src1`, `id_src2` in 4: source registers of the instruction in ID.
- `id_two_src` in 1: ID instruction reads `id_src2`.
- `exe_src1`, `exe_src2` in 4: source registers of the instruction in EXE.
- `exe_wb_en`, `exe_mem_read` in 1: EXE instruction writes back / is a load.
- `exe_dest` in 4: EXE destination register.
- `exe_branch` in 1: taken branch in EXE.
- `mem_wb_en` in 1, `mem_dest` in 4: MEM-stage writeback enable and destination.
- `wb_wb_en` in 1, `wb_dest` in 4: WB-stage writeback enable and destination.
- `mem_req` in 1: MEM stage holds a load or store.
- `mem_ready` in 1: SRAM controller done this cycle.
- `sel_src1`, `sel_src2` out 2: EXE operand selects.
- `stall_front` out 1: hold PC and IF/ID.
- `bubble` out 1: load NOP into ID/EXE.
- `flush` out 1: clear IF/ID and ID/EXE.
- `freeze_all` out 1: hold every pipeline register and the PC.
- `mem_timeout` out 1: sticky watchdog error.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- **Forwarding.** When `fwd_en_q`=0: `sel_srcN`=00.
  - Otherwise `sel_srcN`=01 if `mem_wb_en` && `mem_dest`==`exe_srcN`.
  - Else 10 if `wb_wb_en` && `wb_dest`==`exe_srcN`.
  - Else 00. MEM has priority over WB.
- **Hazard match.** `hit(d, en)` = en && (d==`id_src1` || (`id_two_src` && d==`id_src2`)).
- **Hazard condition (haz).**
  - With `fwd_en_q`=1: haz = `exe_mem_read` && hit(`exe_dest`, `exe_wb_en`).
  - With `fwd_en_q`=0: haz = hit(`exe_dest`, `exe_wb_en`) || hit(`mem_dest`, `mem_wb_en`).
  - WB is never a hazard, because the register file writes before it reads.
- **Freeze.** `freeze_all` = `mem_req` && !`mem_ready`. This is combinational and independent of state.
- **Flush.** `flush` = `exe_branch` && !`freeze_all`.
- **Stall.** `stall_front` = `bubble` = haz && !`freeze_all` && !`exe_branch`.
- **Priority.** Freeze, then flush, then stall. A branch during a freeze is deferred: EXE is held, so `exe_branch` is still high once the freeze releases.
- **FSM** (2 states, registered):
  - RUN → WAIT when `freeze_all`=1.
  - WAIT → RUN when `mem_ready`=1 or `mem_req`=0.
- **Watchdog.** `wait_cnt` clears in RUN and increments each WAIT cycle, saturating at TIMEOUT. When `wait_cnt` reaches TIMEOUT−1 while still frozen, `mem_timeout` sets on the next edge. It stays high until `rst`. `freeze_all` is unaffected.
- **Counters.**
  - `stall_cnt` +1 on every cycle with `stall_front`=1.
  - `flush_cnt` +1 on every cycle with `flush`=1.
  - Both saturate at all-ones and never wrap.
- **Config.** `fwd_en_q` <= `cfg_forward_en` every edge. A change takes effect the cycle after it is sampled.

## Timing
- **Combinational outputs** (same cycle as inputs): `sel_src*`, `stall_front`, `bubble`, `flush`, `freeze_all`.
- **Registered state:** `state`, `wait_cnt`, `mem_timeout`, counters, `fwd_en_q`. Counters update the edge after the event, so they are visible the following cycle.
- **Reset values:**
  - state=RUN, `wait_cnt`=0, `mem_timeout`=0, `stall_cnt`=0, `flush_cnt`=0, `fwd_en_q`=0.
  - With `fwd_en_q`=0 all `sel_src*`=00.
- **Reset mid-WAIT:** FSM returns to RUN and the watchdog clears. `freeze_all` still follows inputs combinationally.
- **Load-use:** exactly one bubble cycle with forwarding on, because the next cycle the load is in MEM. With forwarding off a RAW stalls for up to 2 cycles.

## Test plan
- **MEM over WB priority.** `cfg_forward_en`=1 (after 1 cycle), `exe_src1`=3, `mem_dest`=3/`mem_wb_en`=1, `wb_dest`=3/`wb_wb_en`=1 → `sel_src1`=01. Drop `mem_wb_en` → `sel_src1`=10. Forwarding off → 00.
- **Load-use.** Forwarding on, `exe_mem_read`=1, `exe_dest`=5, `id_src2`=5, `id_two_src`=1 → `stall_front`=`bubble`=1 for one cycle and `stall_cnt` 0→1. Same with `id_two_src`=0 → no stall.
- **Forwarding off.** `mem_dest`=7, `mem_wb_en`=1, `id_src1`=7 → stall. `wb_dest`=7 alone → no stall.
- **Branch plus load-use same cycle** → `flush`=1, `stall_front`=0, `flush_cnt` 0→1.
- **Memory wait.** `mem_req`=1, `mem_ready`=0 for 3 cycles then 1 → `freeze_all` high 3 cycles, WAIT 3 cycles, `flush`/`stall_front` suppressed. A concurrent `exe_branch` flushes on the release cycle.
- **Watchdog.** TIMEOUT=4, freeze held 6 cycles → `mem_timeout` rises after the 4th wait cycle and stays high until `rst`. Counters preloaded to all-ones stay saturated.
